// File: rtl/park_transform_if.sv
// Sample/result bus of the Park transform stage: a valid/ready sample input
// (alpha/beta currents plus sin/cos of the electrical angle) and a one-cycle
// strobed d/q result output.
interface park_transform_if #(
   parameter int DW   = 16,
   parameter int SC_W = 16
);
   logic                   in_valid;
   logic                   in_ready;
   logic signed [DW-1:0]   i_alpha;
   logic signed [DW-1:0]   i_beta;
   logic signed [SC_W-1:0] sin;
   logic signed [SC_W-1:0] cos;
   logic                   out_valid;
   logic signed [DW-1:0]   i_d;
   logic signed [DW-1:0]   i_q;

   // Upstream side: supplies samples, consumes results.
   modport master (
      output in_valid, i_alpha, i_beta, sin, cos,
      input  in_ready, out_valid, i_d, i_q
   );

   // Transform side.
   modport slave (
      input  in_valid, i_alpha, i_beta, sin, cos,
      output in_ready, out_valid, i_d, i_q
   );
endinterface

// File: rtl/park_transform.sv
// Park transform: i_d = a*cos + b*sin, i_q = b*cos - a*sin.
// A single signed multiplier is shared across four product states; results
// are rounded half-up from Q(SC_W-1), saturated to DW bits and registered.
module park_transform #(
   parameter int DW   = 16,
   parameter int SC_W = 16
) (
   input  logic           clk,
   input  logic           rst,
   park_transform_if.slave bus
);
   localparam int PW = DW + SC_W;
   localparam int AW = PW + 1;

   localparam logic signed [AW-1:0] RND     = {{(AW-SC_W+1){1'b0}}, 1'b1, {(SC_W-2){1'b0}}};
   localparam logic signed [AW-1:0] SAT_MAX = {{(AW-DW+1){1'b0}}, {(DW-1){1'b1}}};
   localparam logic signed [AW-1:0] SAT_MIN = {{(AW-DW+1){1'b1}}, {(DW-1){1'b0}}};

   typedef enum logic [2:0] {IDLE, P0, P1, P2, P3} state_t;

   state_t state, state_nxt;

   logic signed [DW-1:0]   a_r, b_r;
   logic signed [SC_W-1:0] sin_r, cos_r;
   logic signed [AW-1:0]   acc_d, acc_q;
   logic signed [AW-1:0]   prod_ext, acc_q_fin;
   logic signed [DW-1:0]   mul_x;
   logic signed [SC_W-1:0] mul_y;
   logic signed [PW-1:0]   prod;
   logic signed [DW-1:0]   d_sat, q_sat;
   logic signed [DW-1:0]   id_r, iq_r;
   logic                   ov_r;
   logic                   accept;

   function automatic logic signed [DW-1:0] scale_sat(input logic signed [AW-1:0] acc);
      logic signed [AW-1:0] r;
      r = (acc + RND) >>> (SC_W-1);
      if (r > SAT_MAX)
         r = SAT_MAX;
      else if (r < SAT_MIN)
         r = SAT_MIN;
      return r[DW-1:0];
   endfunction

   assign bus.in_ready  = (state == IDLE);
   assign bus.out_valid = ov_r;
   assign bus.i_d       = id_r;
   assign bus.i_q       = iq_r;
   assign accept        = bus.in_valid && (state == IDLE);

   // Next-state decode: fixed 4-product walk after each accept.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (accept) state_nxt = P0;
         P0:      state_nxt = P1;
         P1:      state_nxt = P2;
         P2:      state_nxt = P3;
         P3:      state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Shared multiplier operand select and final-step rounding/saturation.
   always_comb begin
      mul_x = a_r;
      mul_y = cos_r;
      case (state)
         P1:      begin mul_x = b_r; mul_y = sin_r; end
         P2:      begin mul_x = b_r; mul_y = cos_r; end
         P3:      begin mul_x = a_r; mul_y = sin_r; end
         default: begin mul_x = a_r; mul_y = cos_r; end
      endcase
      prod      = mul_x * mul_y;
      prod_ext  = AW'(prod);
      acc_q_fin = acc_q - prod_ext;
      d_sat     = scale_sat(acc_d);
      q_sat     = scale_sat(acc_q_fin);
   end

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   // Operand latch, accumulation and registered result/strobe.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_r   <= '0;
         b_r   <= '0;
         sin_r <= '0;
         cos_r <= '0;
         acc_d <= '0;
         acc_q <= '0;
         id_r  <= '0;
         iq_r  <= '0;
         ov_r  <= 1'b0;
      end else begin
         ov_r <= 1'b0;
         case (state)
            IDLE: begin
               if (accept) begin
                  a_r   <= bus.i_alpha;
                  b_r   <= bus.i_beta;
                  sin_r <= bus.sin;
                  cos_r <= bus.cos;
                  acc_d <= '0;
                  acc_q <= '0;
               end
            end
            P0, P1: acc_d <= acc_d + prod_ext;
            P2:     acc_q <= acc_q + prod_ext;
            P3: begin
               acc_q <= acc_q_fin;
               id_r  <= d_sat;
               iq_r  <= q_sat;
               ov_r  <= 1'b1;
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_park_transform.sv
// Directed bench for park_transform: expected d/q results are computed from
// the accepted sample with 64-bit integer arithmetic, queued at accept time,
// and compared when out_valid strobes.
module tb_park_transform;
   localparam int DW   = 16;
   localparam int SC_W = 16;

   typedef struct {
      logic signed [DW-1:0] id;
      logic signed [DW-1:0] iq;
      int                   cyc;
   } exp_t;

   logic clk;
   logic rst;

   park_transform_if #(.DW(DW), .SC_W(SC_W)) intf ();

   park_transform #(.DW(DW), .SC_W(SC_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (intf.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   exp_t                 sb[$];
   int                   acc_cycles[$];
   int                   total = 0;
   int                   bad = 0;
   int                   cyc = 0;
   int                   pulses = 0;
   int                   n_exp = 0;
   bit                   accepted = 0;
   bit                   prev_ov = 0;
   logic signed [DW-1:0] last_id = '0;
   logic signed [DW-1:0] last_iq = '0;

   task automatic chk(input string tag, input longint obs, input longint exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   function automatic logic signed [DW-1:0] sc(input longint acc);
      longint r;
      longint mx;
      mx = (longint'(1) <<< (DW-1)) - 1;
      r  = (acc + (longint'(1) <<< (SC_W-2))) >>> (SC_W-1);
      if (r > mx)
         r = mx;
      else if (r < -mx - 1)
         r = -mx - 1;
      return r[DW-1:0];
   endfunction

   // One clock: observe at negedge (scoreboard push/pop), return 1 ns after posedge.
   task automatic cycle();
      longint a, b, s, c;
      exp_t   e;
      @(negedge clk);
      if (intf.in_valid && intf.in_ready && !rst) begin
         a = intf.i_alpha;
         b = intf.i_beta;
         s = intf.sin;
         c = intf.cos;
         e.id  = sc(a*c + b*s);
         e.iq  = sc(b*c - a*s);
         e.cyc = cyc;
         sb.push_back(e);
         acc_cycles.push_back(cyc);
         n_exp++;
         accepted = 1;
      end
      if (intf.out_valid) begin
         chk("ov_width", longint'(prev_ov), 0);
         if (sb.size() == 0) begin
            chk("no_pending_out", longint'(intf.out_valid), 0);
         end else begin
            e = sb.pop_front();
            chk("i_d", intf.i_d, e.id);
            chk("i_q", intf.i_q, e.iq);
            chk("latency", cyc - e.cyc, 5);
            last_id = intf.i_d;
            last_iq = intf.i_q;
            pulses++;
         end
      end
      prev_ov = intf.out_valid;
      cyc++;
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [DW-1:0] a, input logic [DW-1:0] b,
                       input logic [SC_W-1:0] s, input logic [SC_W-1:0] c);
      int k;
      intf.i_alpha  = a;
      intf.i_beta   = b;
      intf.sin      = s;
      intf.cos      = c;
      intf.in_valid = 1'b1;
      accepted = 0;
      k = 0;
      while (!accepted && k < 20) begin
         cycle();
         k++;
      end
      if (!accepted) chk("accept_timeout", longint'(accepted), 1);
      intf.in_valid = 1'b0;
   endtask

   task automatic wait_out();
      int k;
      k = 0;
      while (sb.size() > 0 && k < 30) begin
         cycle();
         k++;
      end
      if (sb.size() > 0) begin
         chk("result_timeout", sb.size(), 0);
         sb.delete();
      end
      for (int i = 0; i < 3; i++) cycle();
   endtask

   initial begin
      int p0;
      rst = 1'b1;
      intf.in_valid = 1'b0;
      intf.i_alpha  = '0;
      intf.i_beta   = '0;
      intf.sin      = '0;
      intf.cos      = '0;
      cycle();
      cycle();
      chk("rst_in_ready", intf.in_ready, 1);
      chk("rst_out_valid", intf.out_valid, 0);
      chk("rst_i_d", intf.i_d, 0);
      chk("rst_i_q", intf.i_q, 0);
      rst = 1'b0;
      cycle();

      // Angle 0
      send(16'd1000, -16'sd500, 16'h0000, 16'h7FFF);
      wait_out();
      chk("angle0_id", last_id, 1000);
      chk("angle0_iq", last_iq, -500);

      // Angle 90 degrees
      send(16'd1000, -16'sd500, 16'h7FFF, 16'h0000);
      wait_out();
      chk("angle90_id", last_id, -500);
      chk("angle90_iq", last_iq, -1000);

      // Saturation: (-1)*(-1)
      send(16'h8000, 16'h0000, 16'h0000, 16'h8000);
      wait_out();
      chk("sat1_id", last_id, 32767);
      chk("sat1_iq", last_iq, 0);

      // Saturation: non-unit vector
      send(16'd32767, 16'd32767, 16'h7FFF, 16'h7FFF);
      wait_out();
      chk("sat2_id", last_id, 32767);
      chk("sat2_iq", last_iq, 0);

      // Rounding half-up
      send(16'd3, -16'sd3, 16'h0000, 16'h4000);
      wait_out();
      chk("round_id", last_id, 2);
      chk("round_iq", last_iq, -1);

      // Inputs toggled during computation
      send(16'd1234, -16'sd777, 16'h2000, 16'h6000);
      for (int i = 0; i < 4; i++) begin
         intf.i_alpha = 16'($urandom);
         intf.i_beta  = 16'($urandom);
         intf.sin     = 16'($urandom);
         intf.cos     = 16'($urandom);
         cycle();
      end
      wait_out();

      // Back-to-back with in_valid held high
      p0 = pulses;
      acc_cycles.delete();
      send(16'd2000, 16'd300, 16'h3000, 16'h5000);
      intf.in_valid = 1'b1;
      intf.i_alpha  = -16'sd1500;
      intf.i_beta   = 16'd4000;
      intf.sin      = 16'hC000;
      intf.cos      = 16'h6000;
      for (int i = 0; i < 4; i++) begin
         chk("busy_ready_a", intf.in_ready, 0);
         cycle();
      end
      chk("ready_again", intf.in_ready, 1);
      accepted = 0;
      cycle();
      intf.in_valid = 1'b0;
      chk("second_accept", longint'(accepted), 1);
      for (int i = 0; i < 4; i++) begin
         chk("busy_ready_b", intf.in_ready, 0);
         cycle();
      end
      wait_out();
      chk("b2b_spacing", acc_cycles.size() == 2 ? acc_cycles[1] - acc_cycles[0] : -1, 5);
      chk("b2b_pulses", pulses - p0, 2);

      // A few random samples, including full-scale operands
      for (int i = 0; i < 4; i++) begin
         send(16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom));
         wait_out();
      end

      // Reset during P2
      send(16'd1000, -16'sd500, 16'h0000, 16'h7FFF);
      cycle();
      cycle();
      rst = 1'b1;
      #1;
      chk("midrst_i_d", intf.i_d, 0);
      chk("midrst_i_q", intf.i_q, 0);
      chk("midrst_ov", intf.out_valid, 0);
      chk("midrst_ready", intf.in_ready, 1);
      sb.delete();
      n_exp--;
      cycle();
      cycle();
      rst = 1'b0;
      for (int i = 0; i < 8; i++) cycle();
      chk("post_rst_ready", intf.in_ready, 1);
      send(16'd1000, -16'sd500, 16'h0000, 16'h7FFF);
      wait_out();
      chk("post_rst_id", last_id, 1000);
      chk("post_rst_iq", last_iq, -500);

      chk("sb_empty", sb.size(), 0);
      chk("pulse_count", pulses, n_exp);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
